// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN stack master: FSM states, stack commands, opcodes.
package rpn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_B,
    S_POP_A,
    S_EXEC
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP  = 2'd2
  } cmd_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator unit; result is WIDTH+1 bits with carry/borrow on top.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH:0]   result
);

  localparam int unsigned RW = WIDTH + 1;

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;

  assign a_x = {1'b0, a};
  assign b_x = {1'b0, b};

  // SUB inverts B across all WIDTH+1 bits so the top bit reads as borrow
  always_comb begin
    result = '0;
    case (op_t'(op))
      OP_ADD:  result = a_x + b_x;
      OP_SUB:  result = a_x + ~b_x + RW'(1);
      OP_AND:  result = a_x & b_x;
      OP_XOR:  result = a_x ^ b_x;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_master.sv
// RPN token sequencer driving a LIFO stack; tracks depth to reject over/underflow.
module rpn_stack_master
  import rpn_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic                         tok_is_op,
  input  logic [WIDTH-1:0]             tok_data,
  output logic [1:0]                   stack_cmd,
  output logic [WIDTH-1:0]             stack_wdata,
  input  logic                         stack_ack,
  input  logic [WIDTH-1:0]             stack_rdata,
  output logic                         res_valid,
  output logic [WIDTH:0]               res_data,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  state_t           state, state_nx;
  cmd_t             cmd_q, cmd_nx;
  logic [WIDTH-1:0] a_q, a_nx;
  logic [WIDTH-1:0] b_q, b_nx;
  logic [1:0]       op_q, op_nx;
  logic [WIDTH-1:0] wdata_nx;
  logic [WIDTH:0]   res_data_nx;
  logic             res_valid_nx;
  logic             err_nx;
  logic             tok_ready_nx;
  logic [DW-1:0]    depth_nx;
  logic [WIDTH:0]   alu_res;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  assign stack_cmd = cmd_q;

  // Next-state and next-output logic; admission checks happen only in IDLE
  always_comb begin
    state_nx     = state;
    a_nx         = a_q;
    b_nx         = b_q;
    op_nx        = op_q;
    wdata_nx     = stack_wdata;
    res_data_nx  = res_data;
    res_valid_nx = 1'b0;
    err_nx       = 1'b0;
    depth_nx     = depth;
    case (state)
      S_IDLE: begin
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (depth < DW'(DEPTH)) begin
              state_nx = S_PUSH;
              wdata_nx = tok_data;
            end else begin
              err_nx = 1'b1;
            end
          end else if (depth >= DW'(2)) begin
            state_nx = S_POP_B;
            op_nx    = tok_data[1:0];
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_POP_B: begin
        if (stack_ack) begin
          b_nx     = stack_rdata;
          depth_nx = depth - DW'(1);
          state_nx = S_POP_A;
        end
      end
      S_POP_A: begin
        if (stack_ack) begin
          a_nx     = stack_rdata;
          depth_nx = depth - DW'(1);
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        res_data_nx  = alu_res;
        res_valid_nx = 1'b1;
        wdata_nx     = alu_res[WIDTH-1:0];
        state_nx     = S_PUSH;
      end
      S_PUSH: begin
        if (stack_ack) begin
          depth_nx = depth + DW'(1);
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    tok_ready_nx = (state_nx == S_IDLE);
    case (state_nx)
      S_PUSH:           cmd_nx = CMD_PUSH;
      S_POP_B, S_POP_A: cmd_nx = CMD_POP;
      default:          cmd_nx = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= CMD_NOP;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      stack_wdata <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      err         <= 1'b0;
      tok_ready   <= 1'b1;
      depth       <= '0;
    end else begin
      state       <= state_nx;
      cmd_q       <= cmd_nx;
      a_q         <= a_nx;
      b_q         <= b_nx;
      op_q        <= op_nx;
      stack_wdata <= wdata_nx;
      res_data    <= res_data_nx;
      res_valid   <= res_valid_nx;
      err         <= err_nx;
      tok_ready   <= tok_ready_nx;
      depth       <= depth_nx;
    end
  end

endmodule

// File: tb/tb_rpn_stack_master.sv
// Directed bench for rpn_stack_master with an RPN evaluation model and an attached stack model.
module tb_rpn_stack_master;

  localparam int unsigned W = 16;
  localparam int unsigned D = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_is_op = 1'b0;
  logic [W-1:0]  tok_data = '0;
  logic [1:0]    stack_cmd;
  logic [W-1:0]  stack_wdata;
  logic          stack_ack = 1'b0;
  logic [W-1:0]  stack_rdata = '0;
  logic          res_valid;
  logic [W:0]    res_data;
  logic          err;
  logic [6:0]    depth;

  rpn_stack_master #(.DEPTH(D), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_is_op   (tok_is_op),
    .tok_data    (tok_data),
    .stack_cmd   (stack_cmd),
    .stack_wdata (stack_wdata),
    .stack_ack   (stack_ack),
    .stack_rdata (stack_rdata),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .err         (err),
    .depth       (depth)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Evaluation model: what the stack must see and what results/errors must appear
  typedef struct {
    logic [1:0]   cmd;
    logic [W-1:0] data;
  } txn_t;

  txn_t         exp_txn[$];
  logic [W:0]   exp_res[$];
  int           exp_err = 0;
  int           mstack[$];
  int           mdepth = 0;
  int           acc_cyc = 0;
  int           lat_res = -1;
  int           lat_err = -1;
  int           stall_seen = 0;
  logic [W-1:0] last_push = '0;
  logic [W:0]   last_res = '0;

  task automatic model_accept(input logic is_op, input logic [W-1:0] d);
    int a, b, r;
    if (!is_op) begin
      if (mdepth < D) begin
        mstack.push_back(int'(d));
        mdepth++;
        exp_txn.push_back('{2'd1, d});
      end else exp_err++;
    end else if (mdepth >= 2) begin
      b = mstack.pop_back();
      a = mstack.pop_back();
      mdepth -= 2;
      exp_txn.push_back('{2'd2, W'(b)});
      exp_txn.push_back('{2'd2, W'(a)});
      case (d[1:0])
        2'd0:    r = a + b;
        2'd1:    r = a - b;
        2'd2:    r = a & b;
        default: r = a ^ b;
      endcase
      r = r & 32'h1FFFF;
      exp_res.push_back(17'(r));
      mstack.push_back(r & 32'hFFFF);
      mdepth++;
      exp_txn.push_back('{2'd1, W'(r)});
    end else exp_err++;
  endtask

  task automatic model_clear();
    exp_txn.delete();
    exp_res.delete();
    exp_err = 0;
    mstack.delete();
    mdepth = 0;
  endtask

  // Attached stack: acks at negedge (optionally stalling the second pop), updates at posedge
  logic [W-1:0] bstack[$];
  txn_t         seen[$];
  int           stall_left = 0;
  int           pops_run = 0;
  logic         stalling = 1'b0;

  always @(negedge clk) begin
    stalling = 1'b0;
    if (rst) stack_ack = 1'b0;
    else if (stack_cmd == 2'd2 && pops_run == 1 && stall_left > 0) begin
      stack_ack = 1'b0;
      stalling  = 1'b1;
      stall_left--;
    end else stack_ack = (stack_cmd != 2'd0);
    stack_rdata = (bstack.size() > 0) ? bstack[$] : '0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bstack.delete();
      pops_run = 0;
    end else if (stack_ack) begin
      if (stack_cmd == 2'd1) begin
        bstack.push_back(stack_wdata);
        seen.push_back('{2'd1, stack_wdata});
        pops_run = 0;
      end else if (stack_cmd == 2'd2) begin
        void'(bstack.pop_back());
        seen.push_back('{2'd2, '0});
        pops_run++;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    txn_t t;
    #1;
    if (!rst) begin
      if (stack_ack && stack_cmd != 2'd0) begin
        if (exp_txn.size() == 0) chk("unexpected_stack_cmd", 32'(stack_cmd), 32'd0);
        else begin
          t = exp_txn.pop_front();
          chk("stack_cmd_seq", 32'(stack_cmd), 32'(t.cmd));
          if (t.cmd == 2'd1) chk("push_data", 32'(stack_wdata), 32'(t.data));
        end
        if (stack_cmd == 2'd1) last_push = stack_wdata;
      end
      if (res_valid) begin
        last_res = res_data;
        lat_res  = cyc - acc_cyc;
        if (exp_res.size() == 0) chk("unexpected_res", 32'(res_valid), 32'd0);
        else chk("res_data", 32'(res_data), 32'(exp_res.pop_front()));
      end
      if (err) begin
        lat_err = cyc - acc_cyc;
        chk("err_expected", 32'(exp_err > 0), 32'd1);
        if (exp_err > 0) exp_err--;
      end
      if (tok_ready) chk("depth_idle", 32'(depth), 32'(mdepth));
      if (stalling) begin
        stall_seen++;
        chk("stall_cmd", 32'(stack_cmd), 32'd2);
        chk("stall_ready", 32'(tok_ready), 32'd0);
      end
    end
  end

  task automatic send(input logic is_op, input logic [W-1:0] d);
    int n = 0;
    @(negedge clk); #2;
    while (!tok_ready && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    if (!tok_ready) begin
      chk("ready_timeout", 32'(tok_ready), 32'd1);
      return;
    end
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    model_accept(is_op, d);
    @(posedge clk); #1;
    acc_cyc   = cyc - 1;
    tok_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #3;
    while ((!tok_ready || exp_txn.size() != 0) && n < 500) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'(tok_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    seen.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tok_ready"}, 32'(tok_ready), 32'd1);
    chk({tag, "_stack_cmd"}, 32'(stack_cmd), 32'd0);
    chk({tag, "_wdata"}, 32'(stack_wdata), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
  endtask

  initial begin
    int n0;
    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // 7 5 ADD
    send(1'b0, 16'd7);
    send(1'b0, 16'd5);
    send(1'b1, 16'd0);
    wait_idle();
    chk("add_latency", 32'(lat_res), 32'd4);
    chk("add_result", 32'(last_res), 32'h0000C);
    chk("add_depth", 32'(depth), 32'd1);
    chk("add_seq_len", 32'(seen.size()), 32'd5);
    if (seen.size() == 5) begin
      chk("add_seq0", {14'd0, seen[0].cmd, seen[0].data}, {14'd0, 2'd1, 16'd7});
      chk("add_seq1", {14'd0, seen[1].cmd, seen[1].data}, {14'd0, 2'd1, 16'd5});
      chk("add_seq2", 32'(seen[2].cmd), 32'd2);
      chk("add_seq3", 32'(seen[3].cmd), 32'd2);
      chk("add_seq4", {14'd0, seen[4].cmd, seen[4].data}, {14'd0, 2'd1, 16'd12});
    end

    // 3 5 SUB borrows
    do_reset();
    send(1'b0, 16'd3);
    send(1'b0, 16'd5);
    send(1'b1, 16'd1);
    wait_idle();
    chk("sub_result", 32'(last_res), 32'h1FFFE);
    chk("sub_push", 32'(last_push), 32'hFFFE);
    chk("sub_depth", 32'(depth), 32'd1);

    // Underflow: ADD with one entry
    n0 = seen.size();
    lat_err = -1;
    send(1'b1, 16'd0);
    repeat (3) @(negedge clk);
    chk("under_err_latency", 32'(lat_err), 32'd1);
    chk("under_no_traffic", 32'(seen.size()), 32'(n0));
    chk("under_depth", 32'(depth), 32'd1);
    send(1'b0, 16'd9);
    wait_idle();
    chk("after_under_depth", 32'(depth), 32'd2);
    chk("after_under_push", 32'(last_push), 32'd9);

    // Overflow: fill to DEPTH then one more
    do_reset();
    for (int i = 0; i < int'(D); i++) send(1'b0, 16'(i * 3 + 1));
    wait_idle();
    chk("full_depth", 32'(depth), 32'd64);
    n0 = seen.size();
    lat_err = -1;
    send(1'b0, 16'hAAAA);
    repeat (3) @(negedge clk);
    chk("over_err_latency", 32'(lat_err), 32'd1);
    chk("over_no_traffic", 32'(seen.size()), 32'(n0));
    chk("over_depth", 32'(depth), 32'd64);
    send(1'b1, 16'd3);
    wait_idle();
    chk("xor_result", 32'(last_res), 32'h00005);
    chk("xor_depth", 32'(depth), 32'd63);

    // Stall 10 cycles in POP_A
    do_reset();
    send(1'b0, 16'h1234);
    send(1'b0, 16'h0F0F);
    stall_seen = 0;
    stall_left = 10;
    send(1'b1, 16'd1);
    wait_idle();
    chk("stall_cycles", 32'(stall_seen), 32'd10);
    chk("stall_result", 32'(last_res), 32'h00325);
    chk("stall_depth", 32'(depth), 32'd1);

    // Reset during EXEC of AND
    do_reset();
    send(1'b0, 16'h00F0);
    send(1'b0, 16'h0FFF);
    send(1'b1, 16'd2);
    repeat (3) @(negedge clk);
    #3;
    chk("exec_cmd_nop", 32'(stack_cmd), 32'd0);
    chk("exec_not_ready", 32'(tok_ready), 32'd0);
    rst = 1'b1;
    model_clear();
    seen.delete();
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 16'h0055);
    wait_idle();
    chk("post_rst_depth", 32'(depth), 32'd1);
    chk("post_rst_push", 32'(last_push), 32'h0055);

    chk("leftover_txn", 32'(exp_txn.size()), 32'd0);
    chk("leftover_res", 32'(exp_res.size()), 32'd0);
    chk("leftover_err", 32'(exp_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
